// File: rtl/pe_array_16_pkg.sv
// pe_array_16 shared types and constants.
// Build option: define PE_ROUND_EN for round-half-up on MUL/MAC.
package pe_array_16_pkg;

  localparam int LANES      = 16;
  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;
  localparam int ACC_WIDTH  = 40;
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    MODE_MUL  = 2'd0,
    MODE_ADD  = 2'd1,
    MODE_MAC  = 2'd2,
    MODE_PASS = 2'd3
  } mode_e;

  typedef logic signed [ACC_WIDTH-1:0] wide_t;

  localparam wide_t SAT_MAX = 40'sd32767;
  localparam wide_t SAT_MIN = -40'sd32768;

`ifdef PE_ROUND_EN
  localparam wide_t ROUND_BIAS = 40'sd128;
`else
  localparam wide_t ROUND_BIAS = 40'sd0;
`endif

  typedef struct packed {
    logic                  sat;
    logic [DATA_WIDTH-1:0] val;
  } sat_t;

  function automatic sat_t sat_val(input wide_t v);
    sat_t r;
    if (v > SAT_MAX) begin
      r = '{sat: 1'b1, val: 16'h7fff};
    end else if (v < SAT_MIN) begin
      r = '{sat: 1'b1, val: 16'h8000};
    end else begin
      r = '{sat: 1'b0, val: v[DATA_WIDTH-1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_array_16_lane.sv
// One PE lane: multiply/add/MAC/pass with saturating
// registered output and a 40-bit wrapping accumulator.
import pe_array_16_pkg::*;

module pe_lane (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [1:0]            op_mode,
  input  logic                  clear_acc,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  sat_flag
);

  logic signed [DATA_WIDTH-1:0] a_s;
  logic signed [DATA_WIDTH-1:0] b_s;
  logic signed [PROD_WIDTH-1:0] prod_s;
  logic signed [DATA_WIDTH:0]   sum_s;
  wide_t                        prod_x;
  wide_t                        sum_x;
  wide_t                        acc_base;
  wide_t                        acc_q;
  wide_t                        acc_nxt;
  wide_t                        mac_sum;
  sat_t                         pick;

  always_comb begin
    a_s    = a;
    b_s    = b;
    prod_s = a_s * b_s;
    prod_x = {{(ACC_WIDTH-PROD_WIDTH){prod_s[PROD_WIDTH-1]}}, prod_s};
    sum_s  = {a_s[DATA_WIDTH-1], a_s} + {b_s[DATA_WIDTH-1], b_s};
    sum_x  = {{(ACC_WIDTH-DATA_WIDTH-1){sum_s[DATA_WIDTH]}}, sum_s};
    acc_base = clear_acc ? '0 : acc_q;
    mac_sum  = acc_base + prod_x;
    acc_nxt  = clear_acc ? '0 : acc_q;
    pick     = '0;
    unique case (1'b1)
      (op_mode == MODE_MUL): begin
        pick = sat_val((prod_x + ROUND_BIAS) >>> FRAC_BITS);
      end
      (op_mode == MODE_ADD): begin
        pick = sat_val(sum_x);
      end
      (op_mode == MODE_MAC): begin
        acc_nxt = mac_sum;
        pick    = sat_val((mac_sum + ROUND_BIAS) >>> FRAC_BITS);
      end
      default: begin
        pick = '{sat: 1'b0, val: a};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      result   <= '0;
      sat_flag <= 1'b0;
    end else if (en) begin
      acc_q    <= acc_nxt;
      result   <= pick.val;
      sat_flag <= pick.sat;
    end
  end

endmodule

// File: rtl/pe_array_16.sv
// 16-lane fixed-point PE array, one-cycle latency.
// Build option: PE_ROUND_EN enables rounding on MUL/MAC.
import pe_array_16_pkg::*;

module pe_array_16 (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [1:0]                  pe_op_mode,
  input  logic                        pe_clear_acc,
  input  logic [LANES*DATA_WIDTH-1:0] pe_in_a_vec,
  input  logic [LANES*DATA_WIDTH-1:0] pe_in_b_vec,
  output logic [LANES*DATA_WIDTH-1:0] pe_result_vec,
  output logic                        pe_result_valid,
  output logic [LANES-1:0]            pe_sat_flags
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_lane u_lane (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .op_mode   (pe_op_mode),
      .clear_acc (pe_clear_acc),
      .a         (pe_in_a_vec[i*DATA_WIDTH +: DATA_WIDTH]),
      .b         (pe_in_b_vec[i*DATA_WIDTH +: DATA_WIDTH]),
      .result    (pe_result_vec[i*DATA_WIDTH +: DATA_WIDTH]),
      .sat_flag  (pe_sat_flags[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pe_result_valid <= 1'b0;
    end else begin
      pe_result_valid <= en;
    end
  end

endmodule

// File: tb/tb_pe_array_16.sv
// Directed bench for pe_array_16: vector table plus
// hand sequences for stall, lane isolation and reset.
module tb_pe_array_16;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [1:0]   pe_op_mode;
  logic         pe_clear_acc;
  logic [255:0] pe_in_a_vec;
  logic [255:0] pe_in_b_vec;
  logic [255:0] pe_result_vec;
  logic         pe_result_valid;
  logic [15:0]  pe_sat_flags;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pe_array_16 dut (
    .clk             (clk),
    .reset           (reset),
    .en              (en),
    .pe_op_mode      (pe_op_mode),
    .pe_clear_acc    (pe_clear_acc),
    .pe_in_a_vec     (pe_in_a_vec),
    .pe_in_b_vec     (pe_in_b_vec),
    .pe_result_vec   (pe_result_vec),
    .pe_result_valid (pe_result_valid),
    .pe_sat_flags    (pe_sat_flags)
  );

  typedef struct {
    logic [1:0]  mode;
    logic        clr;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        s;
  } vec_t;

  vec_t tbl[17];

  function automatic logic [255:0] rep(input logic [15:0] x);
    return {16{x}};
  endfunction

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic c,
                       input logic [15:0] a, input logic [15:0] b);
    en           = 1'b1;
    pe_op_mode   = m;
    pe_clear_acc = c;
    pe_in_a_vec  = rep(a);
    pe_in_b_vec  = rep(b);
  endtask

  task automatic check_all(input string name, input logic [15:0] r,
                           input logic s, input logic v);
    check({name, ".res"}, pe_result_vec, rep(r));
    check({name, ".sat"}, {240'd0, pe_sat_flags}, {240'd0, {16{s}}});
    check({name, ".vld"}, {255'd0, pe_result_valid}, {255'd0, v});
  endtask

  logic [15:0] rnd_lo;
  logic [15:0] rnd_m1;
  logic [255:0] exp_l3;

  initial begin
`ifdef PE_ROUND_EN
    rnd_lo = 16'h0001;
    rnd_m1 = 16'h0000;
`else
    rnd_lo = 16'h0000;
    rnd_m1 = 16'hffff;
`endif
    tbl[0]  = '{2'd0, 1'b0, 16'h7fff, 16'h7fff, 16'h7fff, 1'b1};
    tbl[1]  = '{2'd0, 1'b0, 16'h8000, 16'h7fff, 16'h8000, 1'b1};
    tbl[2]  = '{2'd0, 1'b0, 16'h8000, 16'h8000, 16'h7fff, 1'b1};
    tbl[3]  = '{2'd1, 1'b0, 16'h7000, 16'h2000, 16'h7fff, 1'b1};
    tbl[4]  = '{2'd1, 1'b0, 16'h0100, 16'hff00, 16'h0000, 1'b0};
    tbl[5]  = '{2'd1, 1'b0, 16'h8000, 16'hffff, 16'h8000, 1'b1};
    tbl[6]  = '{2'd3, 1'b0, 16'h1234, 16'h5555, 16'h1234, 1'b0};
    tbl[7]  = '{2'd2, 1'b1, 16'h0100, 16'h0100, 16'h0100, 1'b0};
    tbl[8]  = '{2'd2, 1'b0, 16'h0100, 16'h0080, 16'h0180, 1'b0};
    tbl[9]  = '{2'd2, 1'b0, 16'h0100, 16'h0080, 16'h0200, 1'b0};
    tbl[10] = '{2'd2, 1'b0, 16'h0100, 16'h0080, 16'h0280, 1'b0};
    tbl[11] = '{2'd0, 1'b0, 16'h0001, 16'h0080, rnd_lo,   1'b0};
    tbl[12] = '{2'd0, 1'b0, 16'hff00, 16'h0180, 16'hfe80, 1'b0};
    tbl[13] = '{2'd0, 1'b0, 16'hffff, 16'h0001, rnd_m1,   1'b0};
    tbl[14] = '{2'd2, 1'b0, 16'h0100, 16'h0080, 16'h0300, 1'b0};
    tbl[15] = '{2'd3, 1'b1, 16'h0042, 16'h0000, 16'h0042, 1'b0};
    tbl[16] = '{2'd2, 1'b0, 16'h0100, 16'h0100, 16'h0100, 1'b0};

    reset = 1'b1;
    drive(2'd0, 1'b0, 16'h0000, 16'h0000);
    en = 1'b0;
    step();
    step();
    check_all("reset", 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;

    // lane 3 only, other lanes multiply zero
    drive(2'd0, 1'b0, 16'h0000, 16'h0000);
    pe_in_a_vec[3*16 +: 16] = 16'h0100;
    pe_in_b_vec[3*16 +: 16] = 16'h0180;
    step();
    exp_l3 = '0;
    exp_l3[3*16 +: 16] = 16'h0180;
    check("lane3.res", pe_result_vec, exp_l3);
    check("lane3.sat", {240'd0, pe_sat_flags}, 256'd0);
    check("lane3.vld", {255'd0, pe_result_valid}, 256'd1);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].mode, tbl[i].clr, tbl[i].a, tbl[i].b);
      step();
      check_all($sformatf("tbl%0d", i), tbl[i].r, tbl[i].s, 1'b1);
    end

    // stall with garbage operands; acc and result must hold
    drive(2'd2, 1'b1, 16'h0100, 16'h0100);
    step();
    check_all("stall.pre", 16'h0100, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      en           = 1'b0;
      pe_op_mode   = 2'($urandom_range(0, 3));
      pe_clear_acc = 1'($urandom_range(0, 1));
      pe_in_a_vec  = {8{$urandom()}};
      pe_in_b_vec  = {8{$urandom()}};
      step();
      check_all($sformatf("stall%0d", k), 16'h0100, 1'b0, 1'b0);
    end
    drive(2'd2, 1'b0, 16'h0100, 16'h0080);
    step();
    check_all("resume", 16'h0180, 1'b0, 1'b1);

    // reset in the middle of a MAC run, with en still high
    drive(2'd2, 1'b1, 16'h0100, 16'h0100);
    step();
    drive(2'd2, 1'b0, 16'h0100, 16'h0100);
    step();
    check_all("mac2", 16'h0200, 1'b0, 1'b1);
    reset = 1'b1;
    drive(2'd2, 1'b0, 16'h7fff, 16'h7fff);
    step();
    check_all("midrst", 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    drive(2'd2, 1'b0, 16'h0100, 16'h0080);
    step();
    check_all("postrst", 16'h0080, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
